xs3_code_converter: RTL and testbench

- Parametrised multi-digit successor to the single-digit BCD→Excess-3 converter.
- Converts a packed word of DIGITS nibbles in either direction: BCD→Excess-3 (mode 0) or Excess-3→BCD (mode 1).
- Processes one digit per clock through a single shared digit converter, with a valid/ready handshake on both sides.
- Flags invalid digits explicitly; there are no don't-care outputs.
- Sits between the keypad/BCD datapath and the display/arithmetic blocks.

---
 rtl/xs3_code_converter.sv | 149 ++++++++++++++
 tb/tb_xs3_code_converter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/xs3_code_converter.sv
// rtl/xs3_code_converter.sv - multi-digit BCD <-> Excess-3 converter, one digit per clock
// A word is latched at accept, converted LSB digit first through one shared converter, then held until taken.

module xs3_digit_conv (
  input  logic       mode,
  input  logic [3:0] din,
  output logic [3:0] dout,
  output logic       err
);

  always_comb begin
    dout = 4'h0;
    err  = 1'b0;
    if (!mode) begin
      if (din <= 4'd9) dout = din + 4'd3;
      else             err  = 1'b1;
    end else begin
      if (din >= 4'd3 && din <= 4'd12) dout = din - 4'd3;
      else                             err  = 1'b1;
    end
  end

endmodule

module xs3_code_converter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [DIGITS-1:0]     out_err,
  output logic                  out_mode,
  output logic                  busy
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   work_q, work_d;
  logic [4*DIGITS-1:0]   res_q, res_d;
  logic [DIGITS-1:0]     err_q, err_d;
  logic                  mode_q, mode_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;

  logic [3:0]            cur_digit;
  logic [3:0]            conv_digit;
  logic                  conv_err;

  always_comb begin
    cur_digit = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CNT_W'(i)) cur_digit = work_q[4*i +: 4];
    end
  end

  xs3_digit_conv u_digit_conv (
    .mode (mode_q),
    .din  (cur_digit),
    .dout (conv_digit),
    .err  (conv_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    res_d   = res_q;
    err_d   = err_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          work_d  = in_data;
          mode_d  = in_mode;
          res_d   = '0;
          err_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            res_d[4*i +: 4] = conv_digit;
            err_d[i]        = conv_err;
          end
        end
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags are registered alongside the state they decode.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      res_q       <= '0;
      err_q       <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      res_q       <= res_d;
      err_q       <= err_d;
      mode_q      <= mode_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = res_q;
  assign out_err   = err_q;
  assign out_mode  = mode_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_xs3_code_converter.sv
// tb/tb_xs3_code_converter.sv - directed checks for xs3_code_converter (DIGITS=4 and DIGITS=1)

module tb_xs3_code_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid, out_mode, busy;
  logic [15:0] out_data;
  logic [3:0]  out_err;

  logic        in_valid1 = 1'b0, in_mode1 = 1'b0, out_ready1 = 1'b0;
  logic [3:0]  in_data1 = '0;
  logic        in_ready1, out_valid1, out_mode1, busy1;
  logic [3:0]  out_data1;
  logic [0:0]  out_err1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xs3_code_converter #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .out_mode(out_mode), .busy(busy)
  );

  xs3_code_converter #(.DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_mode(in_mode1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_err(out_err1), .out_mode(out_mode1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one word on the selected instance and wait for its result; no handshake on the output.
  task automatic send(input bit one, input logic m, input logic [15:0] d, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!(one ? in_ready1 : in_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", {31'b0, (one ? in_ready1 : in_ready)}, 32'd1);
    if (one) begin in_valid1 = 1'b1; in_mode1 = m; in_data1 = d[3:0]; end
    else     begin in_valid  = 1'b1; in_mode  = m; in_data  = d;      end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_valid1 = 1'b0;
    in_data = 16'hFFFF; in_mode = ~m; in_data1 = 4'hF; in_mode1 = ~m;
    n = 0;
    while (!(one ? out_valid1 : out_valid) && n < 50) begin
      if (!one && n == 0) chk("busy_in_conv", {31'b0, busy}, 32'd1);
      @(negedge clk);
      n++;
    end
    chk("result_timeout", {31'b0, (n < 50)}, 32'd1);
    lat = n;
  endtask

  task automatic take(input bit one);
    if (one) out_ready1 = 1'b1; else out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; out_ready1 = 1'b0;
  endtask

  function automatic logic [15:0] to_xs3(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    return r;
  endfunction

  initial begin
    int lat;
    logic [15:0] bcd, xs;

    // Reset state
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", {16'b0, out_data}, 32'h0);
    chk("rst_out_err", {28'b0, out_err}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_out_mode", {31'b0, out_mode}, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_in_ready", {31'b0, in_ready}, 32'd1);
    chk("idle_out_ready_no_effect", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Mode 0 basic with latency
    send(1'b0, 1'b0, 16'h1234, lat);
    chk("m0_1234_data", {16'b0, out_data}, 32'h4567);
    chk("m0_1234_err", {28'b0, out_err}, 32'h0);
    chk("m0_1234_mode", {31'b0, out_mode}, 32'd0);
    chk("m0_1234_latency", lat, 32'd4);
    chk("done_busy", {31'b0, busy}, 32'd1);
    take(1'b0);

    send(1'b0, 1'b1, 16'h4567, lat);
    chk("m1_4567_data", {16'b0, out_data}, 32'h1234);
    chk("m1_4567_err", {28'b0, out_err}, 32'h0);
    chk("m1_4567_mode", {31'b0, out_mode}, 32'd1);
    take(1'b0);

    send(1'b0, 1'b0, 16'h9A05, lat);
    chk("m0_9A05_data", {16'b0, out_data}, 32'hC038);
    chk("m0_9A05_err", {28'b0, out_err}, 32'h4);
    take(1'b0);

    send(1'b0, 1'b1, 16'h2C3F, lat);
    chk("m1_2C3F_data", {16'b0, out_data}, 32'h0900);
    chk("m1_2C3F_err", {28'b0, out_err}, 32'h9);
    take(1'b0);

    // Backpressure: result held, no accept while DONE
    send(1'b0, 1'b0, 16'h1234, lat);
    for (int k = 0; k < 5; k++) begin
      in_valid = (k == 2); in_data = 16'h0000; in_mode = 1'b1;
      @(negedge clk);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_out_data", {16'b0, out_data}, 32'h4567);
      chk("bp_out_err", {28'b0, out_err}, 32'h0);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    chk("bp_mode_kept", {31'b0, out_mode}, 32'd0);
    take(1'b0);
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'b0, out_valid}, 32'd0);

    // Reset after two digits have been converted
    @(negedge clk);
    in_valid = 1'b1; in_mode = 1'b0; in_data = 16'h9999;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_out_data", {16'b0, out_data}, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    send(1'b0, 1'b0, 16'h0000, lat);
    chk("post_rst_data", {16'b0, out_data}, 32'h3333);
    chk("post_rst_err", {28'b0, out_err}, 32'h0);
    take(1'b0);

    // Round trip over a spread of BCD words
    for (int v = 0; v < 10000; v += 37) begin
      bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      send(1'b0, 1'b0, bcd, lat);
      chk("rt_fwd_data", {16'b0, out_data}, {16'b0, to_xs3(bcd)});
      xs = out_data;
      take(1'b0);
      send(1'b0, 1'b1, xs, lat);
      chk("rt_back_data", {16'b0, out_data}, {16'b0, bcd});
      chk("rt_back_err", {28'b0, out_err}, 32'h0);
      take(1'b0);
    end

    // Single-digit build
    send(1'b1, 1'b1, 16'h000C, lat);
    chk("d1_C_data", {28'b0, out_data1}, 32'h9);
    chk("d1_C_err", {31'b0, out_err1}, 32'd0);
    chk("d1_latency", lat, 32'd1);
    take(1'b1);
    send(1'b1, 1'b1, 16'h0002, lat);
    chk("d1_2_data", {28'b0, out_data1}, 32'h0);
    chk("d1_2_err", {31'b0, out_err1}, 32'd1);
    take(1'b1);
    chk("d1_release_in_ready", {31'b0, in_ready1}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
